packet_distributor: RTL and testbench

Packetizes one incoming AXI-Stream of frame data into fixed-size packets and distributes groups of packets round-robin across up to `NUM_OUT` output streams. It is the parametrised successor to the two-way ping-pong stage in the mindy_core frame path: it adds a configurable output count, config latching at group boundaries, a registered output stage for timing closure, and a group-completion counter.

---
 rtl/pd_pkg.sv | 26 ++
 rtl/axis_skid2.sv | 53 +++++
 rtl/packet_distributor.sv | 135 +++++++++++++
 tb/tb_packet_distributor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types and helpers for the packet distributor: buffer entry layout,
// beat geometry and the active-output clamp.
package pd_pkg;

    localparam int PD_DW          = 512;
    localparam int BYTES_PER_BEAT = PD_DW / 8;
    localparam int DEST_W         = 3;

    typedef logic [DEST_W-1:0] dest_t;

    typedef struct packed {
        logic [PD_DW-1:0] data;
        dest_t            dest;
        logic             last;
    } pd_entry_t;

    // Zero means "one output"; anything beyond the physical count saturates.
    function automatic logic [3:0] clamp_nact(input logic [3:0] act, input int unsigned num_out);
        if (act == 4'd0)
            return 4'd1;
        if (32'(act) > num_out)
            return 4'(num_out);
        return act;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// Generic two-entry skid buffer: head drives the output, the skid entry
// absorbs the one beat that arrives while the head is stalled.
module axis_skid2 #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic                 head_v, skid_v;
    logic [PAYLOAD_W-1:0] head_d, skid_d;
    logic                 push, pop;

    assign in_ready  = !skid_v;
    assign push      = in_valid & in_ready;
    assign pop       = head_v & out_ready;
    assign out_data  = head_d;
    assign out_valid = head_v;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head_d <= '0;
            skid_d <= '0;
        end else if (pop) begin
            // Skid is older than any incoming beat, so it always moves up first.
            if (skid_v) begin
                head_d <= skid_d;
                skid_v <= 1'b0;
            end else if (push) begin
                head_d <= in_data;
            end else begin
                head_v <= 1'b0;
            end
        end else if (push) begin
            if (head_v) begin
                skid_d <= in_data;
                skid_v <= 1'b1;
            end else begin
                head_d <= in_data;
                head_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_distributor.sv
// Cuts the input stream into fixed-size packets and sends groups of packets
// round-robin to the active outputs through a registered skid stage.
module packet_distributor
    import pd_pkg::*;
#(
    parameter int DW      = PD_DW,
    parameter int NUM_OUT = 4,
    parameter int CW      = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DW-1:0]         AXIS_IN_TDATA,
    input  logic                  AXIS_IN_TVALID,
    output logic                  AXIS_IN_TREADY,
    output logic [NUM_OUT*DW-1:0] AXIS_OUT_TDATA,
    output logic [NUM_OUT-1:0]    AXIS_OUT_TLAST,
    output logic [NUM_OUT-1:0]    AXIS_OUT_TVALID,
    input  logic [NUM_OUT-1:0]    AXIS_OUT_TREADY,
    input  logic [15:0]           PACKET_SIZE,
    input  logic [31:0]           PACKETS_PER_GROUP,
    input  logic [3:0]            ACTIVE_OUTPUTS,
    output logic [2:0]            CUR_OUTPUT,
    output logic [31:0]           GROUP_COUNT
);

    localparam int          BPB     = BYTES_PER_BEAT * DW / PD_DW;
    localparam logic [31:0] CPP_MAX = 32'((64'd1 << CW) - 64'd1);

    typedef struct packed {
        logic [DW-1:0] data;
        dest_t         dest;
        logic          last;
    } entry_t;

    logic          cfg_vld;
    logic [CW-1:0] cpp_q, cpp_new, cpp;
    logic [31:0]   ppg_q, ppg_new, ppg;
    logic [3:0]    nact_new;
    logic [15:0]   cpp_raw;

    logic [CW-1:0] beat_q;
    logic [31:0]   pkt_q;
    dest_t         dest_q, dest_nxt;
    logic [3:0]    dest_inc;
    logic [31:0]   grp_cnt_q;

    logic   accept, is_last, grp_end, skid_rdy;
    entry_t push_e, head;
    logic   head_v, head_rdy;
    logic [NUM_OUT-1:0]         sel;
    logic [NUM_OUT-1:0][DW-1:0] out_data;

    always_comb begin
        cpp_raw = PACKET_SIZE / 16'(BPB);
        if (cpp_raw == 16'd0)
            cpp_new = CW'(1);
        else if (32'(cpp_raw) > CPP_MAX)
            cpp_new = '1;
        else
            cpp_new = CW'(cpp_raw);
        ppg_new  = (PACKETS_PER_GROUP == 32'd0) ? 32'd1 : PACKETS_PER_GROUP;
        nact_new = clamp_nact(ACTIVE_OUTPUTS, NUM_OUT);
    end

    // Until the first latch completes, a beat taken on that same cycle uses the live inputs.
    assign cpp = cfg_vld ? cpp_q : cpp_new;
    assign ppg = cfg_vld ? ppg_q : ppg_new;

    assign AXIS_IN_TREADY = resetn & skid_rdy;
    assign accept         = AXIS_IN_TVALID & AXIS_IN_TREADY;
    assign is_last        = (beat_q == cpp);
    assign grp_end        = accept & is_last & (pkt_q == ppg);

    // nact only matters at the group boundary, so it is consumed straight from the latch point.
    assign dest_inc = {1'b0, dest_q} + 4'd1;
    assign dest_nxt = (nact_new <= dest_inc) ? '0 : dest_inc[2:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_vld   <= 1'b0;
            cpp_q     <= CW'(1);
            ppg_q     <= 32'd1;
            beat_q    <= CW'(1);
            pkt_q     <= 32'd1;
            dest_q    <= '0;
            grp_cnt_q <= '0;
        end else begin
            if (!cfg_vld || grp_end) begin
                cfg_vld <= 1'b1;
                cpp_q   <= cpp_new;
                ppg_q   <= ppg_new;
            end
            if (accept) begin
                if (is_last) begin
                    beat_q <= CW'(1);
                    pkt_q  <= (pkt_q == ppg) ? 32'd1 : pkt_q + 32'd1;
                end else begin
                    beat_q <= beat_q + CW'(1);
                end
            end
            if (grp_end) begin
                grp_cnt_q <= grp_cnt_q + 32'd1;
                dest_q    <= dest_nxt;
            end
        end
    end

    assign push_e = '{data: AXIS_IN_TDATA, dest: dest_q, last: is_last};

    axis_skid2 #(
        .PAYLOAD_W($bits(entry_t))
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (push_e),
        .in_valid  (accept),
        .in_ready  (skid_rdy),
        .out_data  (head),
        .out_valid (head_v),
        .out_ready (head_rdy)
    );

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        assign sel[k]             = (head.dest == 3'(k));
        assign AXIS_OUT_TVALID[k] = head_v & sel[k];
        assign AXIS_OUT_TLAST[k]  = head_v & sel[k] & head.last;
        assign out_data[k]        = (head_v & sel[k]) ? head.data : '0;
    end

    assign head_rdy       = |(AXIS_OUT_TREADY & sel);
    assign AXIS_OUT_TDATA = out_data;
    assign CUR_OUTPUT     = dest_q;
    assign GROUP_COUNT    = grp_cnt_q;

endmodule

// File: tb/tb_packet_distributor.sv
// Directed bench for packet_distributor: beat tags in the low 32 data bits
// let a handshake monitor rebuild {dest, last, tag} for every delivered beat.
module tb_packet_distributor;

    localparam int DW      = 512;
    localparam int NUM_OUT = 4;
    localparam int CW      = 8;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic [DW-1:0]         AXIS_IN_TDATA = '0;
    logic                  AXIS_IN_TVALID = 1'b0;
    logic                  AXIS_IN_TREADY;
    logic [NUM_OUT*DW-1:0] AXIS_OUT_TDATA;
    logic [NUM_OUT-1:0]    AXIS_OUT_TLAST;
    logic [NUM_OUT-1:0]    AXIS_OUT_TVALID;
    logic [NUM_OUT-1:0]    AXIS_OUT_TREADY = '1;
    logic [15:0]           PACKET_SIZE = 16'd256;
    logic [31:0]           PACKETS_PER_GROUP = 32'd2;
    logic [3:0]            ACTIVE_OUTPUTS = 4'd3;
    logic [2:0]            CUR_OUTPUT;
    logic [31:0]           GROUP_COUNT;

    packet_distributor #(.DW(DW), .NUM_OUT(NUM_OUT), .CW(CW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .AXIS_IN_TDATA     (AXIS_IN_TDATA),
        .AXIS_IN_TVALID    (AXIS_IN_TVALID),
        .AXIS_IN_TREADY    (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA    (AXIS_OUT_TDATA),
        .AXIS_OUT_TLAST    (AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID   (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY   (AXIS_OUT_TREADY),
        .PACKET_SIZE       (PACKET_SIZE),
        .PACKETS_PER_GROUP (PACKETS_PER_GROUP),
        .ACTIVE_OUTPUTS    (ACTIVE_OUTPUTS),
        .CUR_OUTPUT        (CUR_OUTPUT),
        .GROUP_COUNT       (GROUP_COUNT)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] rx[$];
    logic [31:0] held;

    always @(posedge clk) begin
        for (int k = 0; k < NUM_OUT; k++)
            if (AXIS_OUT_TVALID[k] && AXIS_OUT_TREADY[k])
                rx.push_back({28'd0, 3'(k), AXIS_OUT_TLAST[k], AXIS_OUT_TDATA[k*DW +: 32]});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected {dest, last, tag} for beat i under each scenario's configuration.
    function automatic logic [63:0] expv(input int mode, input int i);
        int   d;
        logic l;
        int   g;
        d = 0;
        l = 1'b0;
        g = (i - 1) / 2;
        case (mode)
            1: begin d = ((i - 1) / 8) % 3; l = (i % 4 == 0); end
            3: begin
                d = (i <= 8) ? 0 : (i <= 12) ? 1 : 2;
                l = (i <= 8) ? (i % 4 == 0) : (i % 2 == 0);
            end
            4: begin d = 0; l = 1'b1; end
            5: begin d = (g < 4) ? g : ((g == 5) ? 1 : 0); l = (i % 2 == 0); end
            default: begin d = 0; l = (i % 4 == 0); end
        endcase
        return {28'd0, 3'(d), l, 32'(i)};
    endfunction

    task automatic verify(input string tag, input int n, input int mode);
        check({tag, "_count"}, 64'(rx.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < rx.size())
                check({tag, "_beat"}, rx[i], expv(mode, i + 1));
    endtask

    task automatic do_reset(input logic [15:0] ps, input logic [31:0] ppg, input logic [3:0] act);
        AXIS_IN_TVALID  = 1'b0;
        AXIS_OUT_TREADY = '1;
        resetn          = 1'b0;
        repeat (2) @(negedge clk);
        PACKET_SIZE       = ps;
        PACKETS_PER_GROUP = ppg;
        ACTIVE_OUTPUTS    = act;
        resetn            = 1'b1;
    endtask

    // Streams tags 1..n; optional config change while beat chg_at is offered,
    // and optional stall of output 1 for stlen cycles starting at cycle st0.
    task automatic stream(input int n, input int chg_at, input logic [15:0] ps2,
                          input logic [3:0] act2, input int st0, input int stlen);
        int   nxt;
        int   t;
        logic rdy;
        nxt = 1;
        t   = 0;
        rx.delete();
        while (nxt <= n && t < 300) begin
            @(negedge clk);
            if (t == 1)
                check("latency", {AXIS_OUT_TVALID, AXIS_OUT_TDATA[31:0]}, {4'b0001, 32'd1});
            if (nxt == chg_at) begin
                PACKET_SIZE    = ps2;
                ACTIVE_OUTPUTS = act2;
            end
            if (stlen > 0 && t == st0)
                held = AXIS_OUT_TDATA[DW +: 32];
            if (stlen > 0 && t > st0 && t < st0 + stlen) begin
                check("stall_data", AXIS_OUT_TDATA[DW +: 32], held);
                check("stall_valid", AXIS_OUT_TVALID, 4'b0010);
                check("stall_last", AXIS_OUT_TLAST, 4'b0000);
            end
            if (stlen > 0 && t == st0 + 2)
                check("stall_in_ready", AXIS_IN_TREADY, 1'b0);
            AXIS_OUT_TREADY = (t >= st0 && t < st0 + stlen) ? 4'b1101 : 4'b1111;
            AXIS_IN_TVALID  = 1'b1;
            AXIS_IN_TDATA   = DW'(nxt);
            rdy = AXIS_IN_TREADY;
            if (stlen == 0)
                check("no_idle", rdy, 1'b1);
            @(posedge clk);
            if (rdy)
                nxt++;
            t++;
        end
        check("stream_done", 64'(nxt), 64'(n + 1));
        @(negedge clk);
        AXIS_IN_TVALID  = 1'b0;
        AXIS_OUT_TREADY = '1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3;
        check("rst_in_ready", AXIS_IN_TREADY, 1'b0);
        check("rst_valid", {AXIS_OUT_TVALID, AXIS_OUT_TLAST}, 8'h00);
        check("rst_group", GROUP_COUNT, 32'd0);
        check("rst_cur", CUR_OUTPUT, 3'd0);

        // Baseline rotation: 4-beat packets, 2 per group, outputs 0,1,2.
        do_reset(16'd256, 32'd2, 4'd3);
        @(negedge clk);
        check("first_cycle_ready", AXIS_IN_TREADY, 1'b1);
        rx.delete();
        stream(24, 0, 16'd256, 4'd3, 1000, 0);
        verify("base", 24, 1);
        check("base_group", GROUP_COUNT, 32'd3);
        check("base_cur", CUR_OUTPUT, 3'd0);

        // Output 1 stalls while its head holds tag 10.
        do_reset(16'd256, 32'd2, 4'd3);
        stream(24, 0, 16'd256, 4'd3, 10, 10);
        check("stall_head_tag", held, 32'd10);
        verify("stall", 24, 1);
        check("stall_group", GROUP_COUNT, 32'd3);

        // Packet size shrinks mid-group; takes effect only at the next group.
        do_reset(16'd256, 32'd2, 4'd3);
        stream(16, 3, 16'd128, 4'd3, 1000, 0);
        verify("resize", 16, 3);
        check("resize_group", GROUP_COUNT, 32'd3);
        check("resize_cur", CUR_OUTPUT, 3'd0);

        // All-zero config degenerates to 1-beat packets on output 0.
        do_reset(16'd0, 32'd0, 4'd0);
        stream(6, 0, 16'd0, 4'd0, 1000, 0);
        verify("zero", 6, 4);
        check("zero_group", GROUP_COUNT, 32'd6);
        check("zero_cur", CUR_OUTPUT, 3'd0);

        // Shrink to 2 active outputs while output 3 is being fed.
        do_reset(16'd128, 32'd1, 4'd4);
        stream(14, 7, 16'd128, 4'd2, 1000, 0);
        verify("shrink", 14, 5);
        check("shrink_group", GROUP_COUNT, 32'd7);
        check("shrink_cur", CUR_OUTPUT, 3'd1);

        // Asynchronous reset with both buffer entries occupied.
        do_reset(16'd256, 32'd2, 4'd3);
        AXIS_OUT_TREADY = '0;
        @(negedge clk);
        AXIS_IN_TVALID = 1'b1;
        AXIS_IN_TDATA  = DW'(1);
        @(negedge clk);
        AXIS_IN_TDATA  = DW'(2);
        @(negedge clk);
        AXIS_IN_TVALID = 1'b0;
        check("full_in_ready", AXIS_IN_TREADY, 1'b0);
        check("full_head", {AXIS_OUT_TVALID, AXIS_OUT_TDATA[31:0]}, {4'b0001, 32'd1});
        #2;
        resetn = 1'b0;
        #1;
        check("async_valid", {AXIS_OUT_TVALID, AXIS_OUT_TLAST}, 8'h00);
        check("async_data", AXIS_OUT_TDATA[31:0], 32'd0);
        check("async_in_ready", AXIS_IN_TREADY, 1'b0);
        @(negedge clk);
        AXIS_OUT_TREADY = '1;
        resetn          = 1'b1;
        check("post_rst_group", GROUP_COUNT, 32'd0);
        check("post_rst_cur", CUR_OUTPUT, 3'd0);
        stream(4, 0, 16'd256, 4'd3, 1000, 0);
        verify("post_rst", 4, 6);
        check("post_rst_group2", GROUP_COUNT, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
